// File: rtl/ikbd_pkg.sv
// Shared definitions for the IKBD keyboard matrix scanner: FSM encoding,
// make/break event encoding and a constant-safe ceil(log2) helper.
package ikbd_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LATCH   = 2'd1;
  localparam logic [1:0] ST_WALK    = 2'd2;
  localparam logic [1:0] ST_ADVANCE = 2'd3;

  localparam logic EV_MAKE  = 1'b0;
  localparam logic EV_BREAK = 1'b1;

  // Never returns 0 so derived vector widths stay legal for tiny parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ikbd_evfifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted
// only when a pop frees a slot on the same cycle.
module ikbd_evfifo
  import ikbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW    = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [W-1:0]     data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ikbd_matrix_scan.sv
// Keyboard matrix scanner: drives one row low per scan_tick, walks its
// columns one per cycle, debounces every key and queues make/break events.
module ikbd_matrix_scan
  import ikbd_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 16,
  parameter int DEB   = 3,
  parameter int DEPTH = 8,
  localparam int CODE_W = clog2(ROWS * COLS),
  localparam int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              scan_tick,
  output logic [ROWS-1:0]   row_o,
  input  logic [COLS-1:0]   col_i,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CODE_W-1:0] ev_code,
  output logic              ev_break,
  output logic [CNT_W-1:0]  ev_count,
  output logic              ev_overflow,
  input  logic              ovf_clr
);

  localparam int NKEYS = ROWS * COLS;
  localparam int RW    = clog2(ROWS);
  localparam int CW    = clog2(COLS);
  localparam int DW    = clog2(DEB + 1);

  logic [1:0]               state_q, state_d;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_idx_q, col_idx_d;
  logic [COLS-1:0]          col_q, col_d;
  logic [ROWS-1:0]          row_drv_q, row_drv_d;
  logic [NKEYS-1:0]         stable_q;
  logic [NKEYS-1:0][DW-1:0] cnt_q;
  logic                     ovf_q, ovf_d;

  logic [CODE_W-1:0]        key_idx;
  logic                     walk;
  logic                     raw;
  logic                     differ;
  logic                     flip;
  logic [DW-1:0]            cnt_d;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CODE_W:0]          fifo_head;
  logic                     pop_now;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    row_drv_d = row_drv_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_tick) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        col_d     = col_i;
        col_idx_d = '0;
        state_d   = ST_WALK;
      end
      ST_WALK: begin
        if (col_idx_q == CW'(COLS - 1)) state_d = ST_ADVANCE;
        else                            col_idx_d = col_idx_q + CW'(1);
      end
      ST_ADVANCE: begin
        row_d     = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        row_drv_d = ~(ROWS'(1) << row_d);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_idx_q <= '0;
      col_q     <= '1;
      row_drv_q <= ~ROWS'(1);
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      row_drv_q <= row_drv_d;
    end
  end

  assign row_o = row_drv_q;

  // Debounce: a key flips only after DEB consecutive samples disagree with it.
  assign walk    = (state_q == ST_WALK);
  assign key_idx = CODE_W'(int'(row_q) * COLS + int'(col_idx_q));
  assign raw     = ~col_q[col_idx_q];
  assign differ  = (raw != stable_q[key_idx]);
  assign flip    = walk & differ & (cnt_q[key_idx] == DW'(DEB - 1));

  always_comb begin
    cnt_d = '0;
    if (differ && !flip) cnt_d = cnt_q[key_idx] + DW'(1);
  end

  // A dropped event still commits the new stable state; nothing retries it.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else if (walk) begin
      cnt_q[key_idx] <= cnt_d;
      if (flip) stable_q[key_idx] <= raw;
    end
  end

  assign pop_now = ev_ready & ~fifo_empty;
  assign ovf_d   = (flip & fifo_full & ~pop_now) | (ovf_q & ~ovf_clr);

  always_ff @(posedge clk or negedge res) begin
    if (!res) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  ikbd_evfifo #(
    .DEPTH (DEPTH),
    .W     (CODE_W + 1)
  ) u_evfifo (
    .clk     (clk),
    .res     (res),
    .push_i  (flip),
    .data_i  ({key_idx, (raw ? EV_MAKE : EV_BREAK)}),
    .full_o  (fifo_full),
    .pop_i   (ev_ready),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (ev_count)
  );

  assign ev_valid    = ~fifo_empty;
  assign ev_code     = fifo_head[CODE_W:1];
  assign ev_break    = fifo_head[0];
  assign ev_overflow = ovf_q;

endmodule

// File: tb/tb_ikbd_matrix_scan.sv
// Self-checking bench for ikbd_matrix_scan: a simulated key matrix, a
// scan-level reference model compared every cycle, and directed scenarios.
module tb_ikbd_matrix_scan;

  localparam int ROWS   = 8;
  localparam int COLS   = 16;
  localparam int DEB    = 3;
  localparam int DEPTH  = 4;
  localparam int CODE_W = 7;
  localparam int CNT_W  = 3;
  localparam int NKEYS  = ROWS * COLS;

  logic              clk = 1'b0;
  logic              res;
  logic              scan_tick;
  logic [ROWS-1:0]   row_o;
  logic [COLS-1:0]   col_i;
  logic              ev_valid;
  logic              ev_ready;
  logic [CODE_W-1:0] ev_code;
  logic              ev_break;
  logic [CNT_W-1:0]  ev_count;
  logic              ev_overflow;
  logic              ovf_clr;

  bit [NKEYS-1:0] pressed;
  int total = 0;
  int bad   = 0;

  ikbd_matrix_scan #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DEB   (DEB),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .res         (res),
    .scan_tick   (scan_tick),
    .row_o       (row_o),
    .col_i       (col_i),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_break    (ev_break),
    .ev_count    (ev_count),
    .ev_overflow (ev_overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  // Passive matrix: a closed key pulls its column low when its row is driven low.
  always_comb begin
    col_i = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_o[r] && pressed[r*COLS + c]) col_i[c] = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: timing of a scan as absolute edge numbers, debounce per key
  typedef struct {
    int t;
    int data;
  } pend_t;

  int    edgeN = 0;
  int    nextFree, latchAt, advanceAt, rowM;
  bit    stableM [NKEYS];
  int    cntM [NKEYS];
  pend_t pend [$];
  int    fifoM [$];
  bit    ovfM;

  task automatic modelReset();
    nextFree  = 0;
    latchAt   = -1;
    advanceAt = -1;
    rowM      = 0;
    ovfM      = 1'b0;
    for (int k = 0; k < NKEYS; k++) begin
      stableM[k] = 1'b0;
      cntM[k]    = 0;
    end
    pend.delete();
    fifoM.delete();
  endtask

  task automatic scheduleRow();
    for (int c = 0; c < COLS; c++) begin
      int k;
      bit sample;
      k = rowM * COLS + c;
      sample = pressed[k];
      if (sample == stableM[k]) cntM[k] = 0;
      else begin
        cntM[k] = cntM[k] + 1;
        if (cntM[k] == DEB) begin
          stableM[k] = sample;
          cntM[k]    = 0;
          pend.push_back('{edgeN + 1 + c, k*2 + (sample ? 0 : 1)});
        end
      end
    end
  endtask

  always @(posedge clk) begin : modelProc
    bit popM, pushM, fullM, ovfSet;
    int pdata;
    logic [ROWS-1:0] expRow;
    edgeN++;
    if (!res) modelReset();
    else begin
      popM   = (fifoM.size() > 0) && ev_ready;
      pushM  = 1'b0;
      pdata  = 0;
      ovfSet = 1'b0;
      if (latchAt == edgeN) scheduleRow();
      if (scan_tick && edgeN >= nextFree) begin
        latchAt   = edgeN + 1;
        advanceAt = edgeN + COLS + 2;
        nextFree  = edgeN + COLS + 3;
      end
      if (pend.size() > 0 && pend[0].t == edgeN) begin
        pushM = 1'b1;
        pdata = pend[0].data;
        void'(pend.pop_front());
      end
      fullM = (fifoM.size() == DEPTH);
      if (popM) void'(fifoM.pop_front());
      if (pushM) begin
        if (!fullM || popM) fifoM.push_back(pdata);
        else                ovfSet = 1'b1;
      end
      if (ovfSet)       ovfM = 1'b1;
      else if (ovf_clr) ovfM = 1'b0;
      if (advanceAt == edgeN) rowM = (rowM + 1) % ROWS;
    end
    #1;
    expRow = ~(ROWS'(1) << rowM);
    checkOutput("model_row_o", 32'(row_o), 32'(expRow));
    checkOutput("model_ev_valid", 32'(ev_valid), 32'(fifoM.size() > 0));
    checkOutput("model_ev_count", 32'(ev_count), 32'(fifoM.size()));
    checkOutput("model_ev_overflow", 32'(ev_overflow), 32'(ovfM));
    if (fifoM.size() > 0) begin
      checkOutput("model_ev_code", 32'(ev_code), 32'(fifoM[0] >> 1));
      checkOutput("model_ev_break", 32'(ev_break), 32'(fifoM[0] & 1));
    end
  end

  // One row scan; ev_ready is raised only for the edge readyAt after the tick.
  task automatic scanRow(input int readyAt);
    scan_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    scan_tick = 1'b0;
    for (int e = 1; e <= COLS + 2; e++) begin
      ev_ready = (e == readyAt);
      @(posedge clk);
      @(negedge clk);
    end
    ev_ready = 1'b0;
  endtask

  task automatic scanFrame(input int readyRow, input int readyAt);
    for (int r = 0; r < ROWS; r++) scanRow((r == readyRow) ? readyAt : -1);
  endtask

  task automatic popOne(input string name, input int expCode, input int expBrk);
    checkOutput({name, "_valid"}, 32'(ev_valid), 32'd1);
    checkOutput({name, "_code"}, 32'(ev_code), 32'(expCode));
    checkOutput({name, "_break"}, 32'(ev_break), 32'(expBrk));
    ev_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  int hot [12];
  int resHold = 0;

  task automatic applyStimulus();
    @(negedge clk);
    scan_tick = ($urandom_range(0, 2) == 0);
    ev_ready  = ($urandom_range(0, 3) == 0);
    ovf_clr   = ($urandom_range(0, 63) == 0);
    if ($urandom_range(0, 99) == 0) pressed[hot[$urandom_range(0, 11)]] ^= 1'b1;
    if (!res) begin
      if (resHold == 0) res = 1'b1;
      else resHold--;
    end else if ($urandom_range(0, 4999) == 0) begin
      res     = 1'b0;
      resHold = 2;
    end
  endtask

  initial begin
    res       = 1'b0;
    scan_tick = 1'b0;
    ev_ready  = 1'b0;
    ovf_clr   = 1'b0;
    pressed   = '0;
    repeat (3) @(negedge clk);
    res = 1'b1;
    #1;
    checkOutput("rst_row_o", 32'(row_o), 32'h0FE);
    checkOutput("rst_ev_valid", 32'(ev_valid), 32'd0);
    checkOutput("rst_ev_count", 32'(ev_count), 32'd0);
    checkOutput("rst_ev_overflow", 32'(ev_overflow), 32'd0);
    scanRow(-1);
    checkOutput("first_scan_row_o", 32'(row_o), 32'h0FD);
    for (int r = 1; r < ROWS; r++) scanRow(-1);

    // Short press that does not survive debounce, then a real press
    pressed[8'h25] = 1'b1;
    repeat (2) scanFrame(-1, -1);
    pressed[8'h25] = 1'b0;
    scanFrame(-1, -1);
    pressed[8'h25] = 1'b1;
    repeat (2) scanFrame(-1, -1);
    checkOutput("bounce_no_event", 32'(ev_count), 32'd0);
    scanFrame(-1, -1);
    checkOutput("make_count", 32'(ev_count), 32'd1);
    popOne("make", 'h25, 0);
    repeat (2) scanFrame(-1, -1);
    checkOutput("held_no_event", 32'(ev_count), 32'd0);

    pressed[8'h25] = 1'b0;
    repeat (3) scanFrame(-1, -1);
    checkOutput("break_count", 32'(ev_count), 32'd1);
    popOne("break", 'h25, 1);

    // Overflow: five makes into a four-deep FIFO with no consumer
    for (int c = 0; c < 5; c++) pressed[c] = 1'b1;
    repeat (3) scanFrame(-1, -1);
    checkOutput("ovf_count", 32'(ev_count), 32'd4);
    checkOutput("ovf_flag", 32'(ev_overflow), 32'd1);
    for (int c = 0; c < 4; c++) popOne("ovf_order", c, 0);
    ovf_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ovf_clr = 1'b0;
    checkOutput("ovf_clr", 32'(ev_overflow), 32'd0);

    // Push into a full FIFO on the same cycle as a pop (row 3, column 4 push)
    for (int c = 0; c < 5; c++) pressed[8'h30 + c] = 1'b1;
    repeat (2) scanFrame(-1, -1);
    scanFrame(3, 6);
    checkOutput("full_pushpop_count", 32'(ev_count), 32'd4);
    checkOutput("full_pushpop_ovf", 32'(ev_overflow), 32'd0);
    checkOutput("full_pushpop_head", 32'(ev_code), 32'h31);

    // Reset in the middle of a column walk
    scanRow(-1);
    scan_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    scan_tick = 1'b0;
    repeat (5) @(negedge clk);
    res = 1'b0;
    #1;
    checkOutput("midwalk_rst_row_o", 32'(row_o), 32'h0FE);
    checkOutput("midwalk_rst_valid", 32'(ev_valid), 32'd0);
    checkOutput("midwalk_rst_count", 32'(ev_count), 32'd0);
    checkOutput("midwalk_rst_ovf", 32'(ev_overflow), 32'd0);
    pressed = '0;
    repeat (2) @(negedge clk);
    res = 1'b1;

    // Randomized traffic on a cluster of keys in rows 5 and 6
    for (int i = 0; i < 12; i++) hot[i] = $urandom_range(80, 111);
    for (int n = 0; n < 20000; n++) applyStimulus();
    @(negedge clk);
    res       = 1'b1;
    scan_tick = 1'b0;
    ovf_clr   = 1'b0;
    ev_ready  = 1'b1;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ikbd_matrix_scan.md
IKBD_MATRIX_SCAN -- requirements
Module: ikbd_matrix_scan

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of matrix rows driven.
REQ-002 SHALL have parameter COLS, default 16, number of matrix columns sensed.
REQ-003 SHALL have parameter DEB, default 3, number of consecutive differing samples that flip a key's state (range 1..15).
REQ-004 SHALL have parameter DEPTH, default 8, event FIFO depth (power of 2, at least 2).
REQ-005 SHALL derive CODE_W = clog2(ROWS*COLS) and CNT_W = clog2(DEPTH+1).
REQ-006 Port: clk  in  1  single clock, all logic on rising edge.
REQ-007 Port: res  in  1  reset, asynchronous, active-low.
REQ-008 Port: scan_tick  in  1  one-cycle strobe that starts the scan of the current row.
REQ-009 Port: row_o  out  ROWS  row drive, active-low one-hot.
REQ-010 Port: col_i  in  COLS  column sense, active-low (0 = key closed).
REQ-011 Port: ev_valid  out  1  FIFO non-empty.
REQ-012 Port: ev_ready  in  1  consumer accepts the head event.
REQ-013 Port: ev_code  out  CODE_W  head key code = row*COLS + col.
REQ-014 Port: ev_break  out  1  head event type: 0 = make, 1 = break.
REQ-015 Port: ev_count  out  CNT_W  FIFO occupancy.
REQ-016 Port: ev_overflow  out  1  sticky flag: an event was dropped.
REQ-017 Port: ovf_clr  in  1  one-cycle clear of ev_overflow.

Function
REQ-018 The FSM SHALL have states IDLE, LATCH, WALK and ADVANCE.
- IDLE: on scan_tick go to LATCH.
- LATCH: register col_i into col_q; go to WALK with col = 0.
- WALK: process one column per cycle; after col = COLS-1 go to ADVANCE.
- ADVANCE: row = (row == ROWS-1) ? 0 : row+1; go to IDLE.
REQ-019 scan_tick outside IDLE SHALL be ignored; a full row scan SHALL take COLS+2 cycles after the tick.
REQ-020 row_o SHALL be registered, drive only the current row low, and change only on the ADVANCE cycle; settle time is the interval up to the next scan_tick.
REQ-021 Each key SHALL hold a stable bit (1 = pressed) and a counter cnt of CNT width clog2(DEB+1).
REQ-022 In WALK, with raw = ~col_q[col] and k = row*COLS+col:
- if raw == stable[k], cnt[k] SHALL be set to 0;
- else if cnt[k] == DEB-1, stable[k] SHALL be set to raw, cnt[k] to 0, and the event {k, ~raw} pushed;
- otherwise cnt[k] SHALL increment.
REQ-023 Per WALK cycle, at most one event SHALL be pushed; events SHALL leave the FIFO in push order.
REQ-024 The FIFO SHALL be first-word-fall-through: ev_code and ev_break SHALL be valid whenever ev_valid = 1; a pop occurs when ev_valid & ev_ready.
REQ-025 A push when full SHALL be accepted if a pop occurs in the same cycle; otherwise it SHALL be dropped and ev_overflow set.
REQ-026 A dropped event SHALL still update stable[k]; no retry.
REQ-027 ev_overflow SHALL clear on ovf_clr; a set and a clear in the same cycle SHALL leave it set.
REQ-028 Push and pop in the same cycle when not full or empty SHALL leave ev_count unchanged; pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 While res = 0, outputs SHALL take these values asynchronously:
- state IDLE, row = 0, row_o = ~1 (row 0 low);
- all stable and cnt = 0;
- FIFO empty, ev_valid = 0, ev_count = 0, ev_overflow = 0.
REQ-030 Reset mid-WALK SHALL discard the partial row; no event from it SHALL appear.

Structure
REQ-031 Shared package ikbd_pkg SHALL hold the FSM state encoding, the clog2 function and the make/break encoding constants.
REQ-032 The FIFO SHALL be sub-module ikbd_evfifo, parametrised by DEPTH and data width CODE_W+1, with push/full/pop/empty/count.

Verification (ROWS=8, COLS=16, DEB=3, DEPTH=4)
REQ-033 Reset release -> row_o = 8'hFE, ev_valid = 0, ev_count = 0, ev_overflow = 0; row_o is 8'hFD after the first scan.
REQ-034 Key row 2 col 5 held across 3 scans of row 2 -> exactly one event: code 0x25, break = 0; no further events while the key is held.
REQ-035 Key row 2 col 5 closed for 2 scans, then open for 1 -> no event, cnt returns to 0.
REQ-036 Key 0x25 released after being stable, for 3 scans -> event 0x25, break = 1.
REQ-037 ev_ready = 0, then 5 distinct presses -> ev_count = 4, ev_overflow = 1, first 4 events in order; ovf_clr -> ev_overflow = 0.
REQ-038 Full FIFO with ev_ready = 1 and a push in the same cycle -> ev_count stays 4 and ev_overflow stays 0; res low during WALK -> reset values immediately.
